// File: rtl/alu_exec_unit.sv
// Handshaked 32-bit ALU with an iterative one-bit-per-cycle shifter.
// Define ALU_FAST_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
module alu_exec_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALU_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_result,
    output logic             zero,
    output logic             busy
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    localparam logic [3:0] OpAdd  = 4'd0;
    localparam logic [3:0] OpSub  = 4'd1;
    localparam logic [3:0] OpSll  = 4'd2;
    localparam logic [3:0] OpSlt  = 4'd3;
    localparam logic [3:0] OpSltu = 4'd4;
    localparam logic [3:0] OpXor  = 4'd5;
    localparam logic [3:0] OpSrl  = 4'd6;
    localparam logic [3:0] OpSra  = 4'd7;
    localparam logic [3:0] OpOr   = 4'd8;
    localparam logic [3:0] OpAnd  = 4'd9;

`ifdef ALU_FAST_SHIFT_EN
    localparam bit FastShift = 1'b1;
`else
    localparam bit FastShift = 1'b0;
`endif

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;

    logic [4:0]       shamt;
    logic             is_shift;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] acc_step;

    assign shamt    = src_b[4:0];
    assign is_shift = (ALU_control == OpSll) || (ALU_control == OpSrl) ||
                      (ALU_control == OpSra);

    always_comb begin
        alu_res = '0;
        case (ALU_control)
            OpAdd:   alu_res = src_a + src_b;
            OpSub:   alu_res = src_a - src_b;
            OpSll:   alu_res = src_a << shamt;
            OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OpSltu:  alu_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
            OpXor:   alu_res = src_a ^ src_b;
            OpSrl:   alu_res = src_a >> shamt;
            OpSra:   alu_res = $signed(src_a) >>> shamt;
            OpOr:    alu_res = src_a | src_b;
            OpAnd:   alu_res = src_a & src_b;
            default: alu_res = '0;
        endcase
    end

    // One step of the iterative shifter, using the captured opcode.
    always_comb begin
        acc_step = acc_q;
        case (op_q)
            OpSll:   acc_step = {acc_q[WIDTH-2:0], 1'b0};
            OpSrl:   acc_step = {1'b0, acc_q[WIDTH-1:1]};
            OpSra:   acc_step = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
            default: acc_step = acc_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    op_d = ALU_control;
                    if (is_shift && (shamt != 5'd0) && !FastShift) begin
                        acc_d   = src_a;
                        cnt_d   = shamt;
                        state_d = StShift;
                    end else begin
                        result_d = alu_res;
                        state_d  = StDone;
                    end
                end
            end
            StShift: begin
                acc_d = acc_step;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    result_d = acc_step;
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            result_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
        end
    end

    assign in_ready   = (state_q == StIdle);
    assign out_valid  = (state_q == StDone);
    assign busy       = (state_q != StIdle);
    assign ALU_result = result_q;
    assign zero       = (result_q == '0);

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL provide parameter: WIDTH, 32, operand/result width in bits (shift amount is src_b[4:0], so WIDTH is fixed at 32 in this revision).
REQ-002 SHALL provide port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL provide port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port: in_valid  input  1  operation request is present.
REQ-005 SHALL provide port: in_ready  output  1  unit accepts a request this cycle.
REQ-006 SHALL provide port: ALU_control  input  4  operation code from the ALU decoder.
REQ-007 SHALL provide port: src_a  input  WIDTH  first operand.
REQ-008 SHALL provide port: src_b  input  WIDTH  second operand; bits [4:0] are the shift amount.
REQ-009 SHALL provide port: out_valid  output  1  result is present.
REQ-010 SHALL provide port: out_ready  input  1  consumer takes the result.
REQ-011 SHALL provide port: ALU_result  output  WIDTH  registered result.
REQ-012 SHALL provide port: zero  output  1  high when ALU_result == 0.
REQ-013 SHALL provide port: busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL decode ALU_control: 0 ADD, 1 SUB, 2 SLL, 3 SLT (signed, result 1/0), 4 SLTU (unsigned, result 1/0), 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND; codes 10-15 SHALL produce result 0.
REQ-015 SHALL wrap ADD/SUB modulo 2^WIDTH; no overflow or carry output.
REQ-016 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-017 SHALL drive in_ready=1 only in IDLE; a request is accepted when in_valid && in_ready.
REQ-018 SHALL capture ALU_control, src_a, src_b at acceptance; later input changes SHALL NOT affect the operation in progress.
REQ-019 SHALL, for non-shift codes, or shift codes with src_b[4:0]==0, register the result and move IDLE->DONE, giving out_valid one cycle after acceptance.
REQ-020 SHALL, for SLL/SRL/SRA with shift amount N>0, move IDLE->SHIFT, loading the accumulator with src_a and a 5-bit counter with N.
REQ-021 SHALL in SHIFT shift the accumulator one bit per cycle (SLL zero-fill left; SRL zero-fill right; SRA replicate bit WIDTH-1) and decrement the counter; on the cycle the counter is 1 it SHALL perform the last shift and go to DONE; out_valid SHALL rise N+1 cycles after acceptance.
REQ-022 SHALL in DONE hold out_valid=1 and ALU_result/zero stable until out_ready=1; on that cycle it SHALL return to IDLE.
REQ-023 SHALL keep ALU_result holding the last delivered value while in IDLE and SHIFT; zero SHALL always reflect ALU_result.
REQ-024 SHALL ignore out_ready outside DONE and ignore in_valid outside IDLE.
REQ-025 SHALL NOT overlap operations; minimum issue interval is 2 cycles (accept, deliver with out_ready=1).

Reset
REQ-026 SHALL on rst_n=0, asynchronously and regardless of state, force state IDLE, ALU_result=0, zero=1, out_valid=0, busy=0, counter=0; in_ready=1 after reset is released.
REQ-027 SHALL discard any operation in progress at reset; no result for it is ever delivered.

Configuration
REQ-028 SHALL, when macro ALU_FAST_SHIFT_EN is defined, execute all shifts with a single-cycle barrel shifter, latency 1 like other codes; the SHIFT state SHALL never be entered.
REQ-029 SHALL, when ALU_FAST_SHIFT_EN is undefined, use the iterative shifter of REQ-020/REQ-021; results SHALL be bit-identical in both builds.

Verification
REQ-030 SHALL cover: reset asserted -> ALU_result=0, zero=1, out_valid=0, in_ready=1.
REQ-031 SHALL cover: code 1, src_a=5, src_b=5, out_ready=1 -> out_valid after 1 cycle, ALU_result=0, zero=1.
REQ-032 SHALL cover: code 3, src_a=0xFFFFFFFF, src_b=1 -> 1; code 4 same operands -> 0.
REQ-033 SHALL cover: code 7, src_a=0x80000000, src_b=4 -> ALU_result=0xF8000000, out_valid 5 cycles after acceptance (1 cycle with ALU_FAST_SHIFT_EN).
REQ-034 SHALL cover: code 0, 0xFFFFFFFF+1 with out_ready=0 for 3 cycles -> ALU_result=0 and out_valid held, in_ready=0, then released on out_ready=1; code 12 -> 0.
REQ-035 SHALL cover: code 2, src_a=1, src_b=31, rst_n pulsed low during SHIFT -> IDLE, out_valid=0, no result delivered; next request completes normally.
